// File: rtl/custom_mem_arbiter_if.sv
// custom_mem_arbiter_if: request/response bundle between custom_cpu, the arbiter and the memory port.
// Ports: I channel (i_req_*/i_rsp_*), D channel (d_req_*/d_rsp_*), downstream port (m_req_*/m_rsp_*).
// Modports: master = arbiter view (owns the downstream request), slave = cpu/memory side view.
interface custom_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch channel
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic [DATA_W-1:0] i_rsp_data;
  logic              i_rsp_valid;
  logic              i_rsp_ready;
  // data channel
  logic                i_unused_pad;
  logic                d_req_rd;
  logic                d_req_wr;
  logic [ADDR_W-1:0]   d_req_addr;
  logic [DATA_W-1:0]   d_req_wdata;
  logic [DATA_W/8-1:0] d_req_wstrb;
  logic                d_req_ready;
  logic [DATA_W-1:0]   d_rsp_data;
  logic                d_rsp_valid;
  logic                d_rsp_ready;
  // downstream memory port
  logic                m_req_valid;
  logic                m_req_wen;
  logic [ADDR_W-1:0]   m_req_addr;
  logic [DATA_W-1:0]   m_req_wdata;
  logic [DATA_W/8-1:0] m_req_wstrb;
  logic                m_req_ready;
  logic [DATA_W-1:0]   m_rsp_data;
  logic                m_rsp_valid;
  logic                m_rsp_ready;

  modport master (
    input  i_req_valid, i_req_addr, i_rsp_ready,
    output i_req_ready, i_rsp_data, i_rsp_valid,
    input  d_req_rd, d_req_wr, d_req_addr, d_req_wdata, d_req_wstrb, d_rsp_ready,
    output d_req_ready, d_rsp_data, d_rsp_valid,
    output m_req_valid, m_req_wen, m_req_addr, m_req_wdata, m_req_wstrb, m_rsp_ready,
    input  m_req_ready, m_rsp_data, m_rsp_valid
  );

  modport slave (
    output i_req_valid, i_req_addr, i_rsp_ready,
    input  i_req_ready, i_rsp_data, i_rsp_valid,
    output d_req_rd, d_req_wr, d_req_addr, d_req_wdata, d_req_wstrb, d_rsp_ready,
    input  d_req_ready, d_rsp_data, d_rsp_valid,
    input  m_req_valid, m_req_wen, m_req_addr, m_req_wdata, m_req_wstrb, m_rsp_ready,
    output m_req_ready, m_rsp_data, m_rsp_valid
  );
endinterface

// File: rtl/custom_mem_arbiter.sv
// custom_mem_arbiter: shares one memory port between the cpu I-fetch and D channels, one
// transaction at a time, routing read data back to its owner and counting grants/stalls.
// Ports: clk, rst (sync, active-high), bus (custom_mem_arbiter_if.master), cnt_grant_i/d, cnt_stall, proto_err.
// Option: define CUSTOM_ARB_RR_EN for round-robin on simultaneous requests (default: D over I).
module custom_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  custom_mem_arbiter_if.master bus,
  output logic [CNT_W-1:0]    cnt_grant_i,
  output logic [CNT_W-1:0]    cnt_grant_d,
  output logic [CNT_W-1:0]    cnt_stall,
  output logic                proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  state_t state_q;
  logic   owner_d_q;  // 1 = D channel owns the transaction, 0 = I channel
  logic   wen_q;

  logic d_any, any_req, pick_d, in_req, in_rsp;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;

`ifdef CUSTOM_ARB_RR_EN
  logic last_d_q;     // channel granted last; the other one wins a tie
`endif

  always_comb begin
    d_any   = bus.d_req_rd | bus.d_req_wr;
    any_req = bus.i_req_valid | d_any;
`ifdef CUSTOM_ARB_RR_EN
    pick_d  = d_any & (~bus.i_req_valid | ~last_d_q);
`else
    pick_d  = d_any;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_d_q   <= 1'b0;
      wen_q       <= 1'b0;
      cnt_grant_i <= '0;
      cnt_grant_d <= '0;
      cnt_stall   <= '0;
      proto_err   <= 1'b0;
`ifdef CUSTOM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      if (any_req && state_q != S_REQ)
        cnt_stall <= cnt_stall + CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q   <= S_REQ;
            owner_d_q <= pick_d;
            // rd+wr together is resolved as a write
            wen_q     <= pick_d & bus.d_req_wr;
`ifdef CUSTOM_ARB_RR_EN
            last_d_q  <= pick_d;
`endif
            if (pick_d) begin
              cnt_grant_d <= cnt_grant_d + CNT_W'(1);
              if (bus.d_req_rd && bus.d_req_wr)
                proto_err <= 1'b1;
            end else begin
              cnt_grant_i <= cnt_grant_i + CNT_W'(1);
            end
          end
        end
        S_REQ: begin
          if (bus.m_req_ready)
            state_q <= wen_q ? S_IDLE : S_RSP;
        end
        S_RSP: begin
          if (bus.m_rsp_valid && bus.m_rsp_ready)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Request fields come straight from the owner's inputs; the requester holds them stable in REQ.
  always_comb begin
    in_req    = (state_q == S_REQ);
    in_rsp    = (state_q == S_RSP);
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    if (in_req) begin
      req_addr = owner_d_q ? bus.d_req_addr : bus.i_req_addr;
      if (owner_d_q && wen_q) begin
        req_wdata = bus.d_req_wdata;
        req_wstrb = bus.d_req_wstrb;
      end
    end
  end

  always_comb begin
    bus.m_req_valid = in_req;
    bus.m_req_wen   = in_req & wen_q;
    bus.m_req_addr  = req_addr;
    bus.m_req_wdata = req_wdata;
    bus.m_req_wstrb = req_wstrb;

    bus.i_req_ready = in_req & ~owner_d_q & bus.m_req_ready;
    bus.d_req_ready = in_req &  owner_d_q & bus.m_req_ready;

    // responses arriving outside RSP are left unacknowledged
    bus.m_rsp_ready = in_rsp & (owner_d_q ? bus.d_rsp_ready : bus.i_rsp_ready);
    bus.i_rsp_valid = in_rsp & ~owner_d_q & bus.m_rsp_valid;
    bus.d_rsp_valid = in_rsp &  owner_d_q & bus.m_rsp_valid;
    bus.i_rsp_data  = (in_rsp & ~owner_d_q) ? bus.m_rsp_data : '0;
    bus.d_rsp_data  = (in_rsp &  owner_d_q) ? bus.m_rsp_data : '0;
  end

endmodule

// File: tb/tb_custom_mem_arbiter.sv
// tb_custom_mem_arbiter: directed bench for custom_mem_arbiter.
// Drives both cpu channels and plays the memory side by hand, checking each cycle inline.
// Expected tie-break order follows CUSTOM_ARB_RR_EN when it is defined.
module tb_custom_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cnt_grant_i, cnt_grant_d, cnt_stall;
  logic        proto_err;
  int          checks = 0;
  int          errors = 0;

  custom_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  custom_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_grant_i(cnt_grant_i),
    .cnt_grant_d(cnt_grant_d),
    .cnt_stall  (cnt_stall),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1-2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0; bus.i_rsp_ready = 1'b0;
    bus.d_req_rd = 1'b1; bus.d_req_wr = 1'b0; bus.d_req_addr = 32'h0;
    bus.d_req_wdata = 32'h0; bus.d_req_wstrb = 4'h0; bus.d_rsp_ready = 1'b0;
    bus.m_req_ready = 1'b0; bus.m_rsp_valid = 1'b0; bus.m_rsp_data = 32'h0;
    tick(); tick();
    #1;
    checks++; if (bus.i_req_ready !== 1'b0) begin errors++; $display("FAIL rst_i_req_ready: got %0h expected 0", bus.i_req_ready); end
    checks++; if (bus.d_req_ready !== 1'b0) begin errors++; $display("FAIL rst_d_req_ready: got %0h expected 0", bus.d_req_ready); end
    checks++; if (bus.m_req_valid !== 1'b0) begin errors++; $display("FAIL rst_m_req_valid: got %0h expected 0", bus.m_req_valid); end
    checks++; if (bus.m_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_m_rsp_ready: got %0h expected 0", bus.m_rsp_ready); end
    checks++; if (bus.i_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got i=%0h d=%0h expected 0", bus.i_rsp_valid, bus.d_rsp_valid); end
    checks++; if (bus.m_req_addr !== 32'h0 || bus.m_req_wdata !== 32'h0 || bus.m_req_wstrb !== 4'h0) begin errors++; $display("FAIL rst_m_req_fields: got addr=%0h wdata=%0h strb=%0h expected 0", bus.m_req_addr, bus.m_req_wdata, bus.m_req_wstrb); end
    checks++; if (cnt_grant_i !== 32'd0 || cnt_grant_d !== 32'd0 || cnt_stall !== 32'd0) begin errors++; $display("FAIL rst_counters: got gi=%0d gd=%0d st=%0d expected 0", cnt_grant_i, cnt_grant_d, cnt_stall); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %0h expected 0", proto_err); end
    bus.i_req_valid = 1'b0; bus.d_req_rd = 1'b0;
    rst = 1'b0;
    tick();
    #1;
    checks++; if (cnt_stall !== 32'd0) begin errors++; $display("FAIL rst_release_stall: got %0d expected 0", cnt_stall); end
  endtask

  task automatic test_i_read();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_0010;
    #1;
    checks++; if (bus.i_req_ready !== 1'b0) begin errors++; $display("FAIL iread_idle_ready: got %0h expected 0", bus.i_req_ready); end
    tick();  // granted -> REQ
    checks++; if (bus.m_req_valid !== 1'b1 || bus.m_req_wen !== 1'b0) begin errors++; $display("FAIL iread_req: got valid=%0h wen=%0h expected 1/0", bus.m_req_valid, bus.m_req_wen); end
    checks++; if (bus.m_req_addr !== 32'h0000_0010 || bus.m_req_wstrb !== 4'h0) begin errors++; $display("FAIL iread_addr: got addr=%0h strb=%0h expected 10/0", bus.m_req_addr, bus.m_req_wstrb); end
    bus.m_req_ready = 1'b1;
    #1;
    checks++; if (bus.i_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0) begin errors++; $display("FAIL iread_req_ready: got i=%0h d=%0h expected 1/0", bus.i_req_ready, bus.d_req_ready); end
    tick();  // -> RSP
    bus.i_req_valid = 1'b0; bus.m_req_ready = 1'b0;
    bus.m_rsp_valid = 1'b1; bus.m_rsp_data = 32'h2408_0001; bus.i_rsp_ready = 1'b1;
    #1;
    checks++; if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_data !== 32'h2408_0001) begin errors++; $display("FAIL iread_rsp: got valid=%0h data=%0h expected 1/24080001", bus.i_rsp_valid, bus.i_rsp_data); end
    checks++; if (bus.m_rsp_ready !== 1'b1 || bus.d_rsp_valid !== 1'b0) begin errors++; $display("FAIL iread_rsp_route: got m_rdy=%0h d_vld=%0h expected 1/0", bus.m_rsp_ready, bus.d_rsp_valid); end
    tick();  // -> IDLE
    bus.m_rsp_valid = 1'b0; bus.i_rsp_ready = 1'b0;
    #1;
    checks++; if (bus.i_rsp_valid !== 1'b0 || bus.m_req_valid !== 1'b0) begin errors++; $display("FAIL iread_done: got i_vld=%0h m_vld=%0h expected 0", bus.i_rsp_valid, bus.m_req_valid); end
    checks++; if (cnt_grant_i !== 32'd1 || cnt_grant_d !== 32'd0) begin errors++; $display("FAIL iread_grants: got gi=%0d gd=%0d expected 1/0", cnt_grant_i, cnt_grant_d); end
    checks++; if (cnt_stall !== 32'd1) begin errors++; $display("FAIL iread_stall: got %0d expected 1", cnt_stall); end
  endtask

  task automatic test_d_write();
    bus.d_req_wr = 1'b1; bus.d_req_addr = 32'h0000_0100;
    bus.d_req_wdata = 32'hDEAD_BEEF; bus.d_req_wstrb = 4'hF;
    tick();  // granted -> REQ
    for (int k = 0; k < 4; k++) begin
      bus.m_req_ready = (k == 3);
      #1;
      checks++; if (bus.m_req_valid !== 1'b1 || bus.m_req_wen !== 1'b1) begin errors++; $display("FAIL dwr_req_c%0d: got valid=%0h wen=%0h expected 1/1", k, bus.m_req_valid, bus.m_req_wen); end
      checks++; if (bus.m_req_addr !== 32'h100 || bus.m_req_wdata !== 32'hDEAD_BEEF || bus.m_req_wstrb !== 4'hF) begin errors++; $display("FAIL dwr_fields_c%0d: got addr=%0h wdata=%0h strb=%0h expected 100/deadbeef/f", k, bus.m_req_addr, bus.m_req_wdata, bus.m_req_wstrb); end
      checks++; if (bus.d_req_ready !== (k == 3) || bus.i_req_ready !== 1'b0) begin errors++; $display("FAIL dwr_ready_c%0d: got d=%0h i=%0h expected %0h/0", k, bus.d_req_ready, bus.i_req_ready, (k == 3)); end
      tick();
    end
    bus.d_req_wr = 1'b0; bus.m_req_ready = 1'b0;
    #1;
    checks++; if (bus.m_req_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin errors++; $display("FAIL dwr_done: got m_vld=%0h d_rsp=%0h expected 0", bus.m_req_valid, bus.d_rsp_valid); end
    checks++; if (cnt_grant_d !== 32'd1 || cnt_stall !== 32'd2) begin errors++; $display("FAIL dwr_counters: got gd=%0d st=%0d expected 1/2", cnt_grant_d, cnt_stall); end
  endtask

  task automatic test_simultaneous();
    logic        first_d, exp_d;
    logic [31:0] exp_data;
`ifdef CUSTOM_ARB_RR_EN
    first_d = 1'b0;  // D was granted last, so I wins the tie
`else
    first_d = 1'b1;
`endif
    for (int r = 0; r < 2; r++) begin
      bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_0040;
      bus.d_req_rd = 1'b1; bus.d_req_addr = 32'h0000_0200;
      for (int g = 0; g < 2; g++) begin
        exp_d = (g == 0) ? first_d : ~first_d;
        exp_data = {24'hA5A5A5, 4'(r), 4'(g)};
        tick();  // grant -> REQ
        checks++; if (bus.m_req_addr !== (exp_d ? 32'h200 : 32'h40) || bus.m_req_wen !== 1'b0) begin errors++; $display("FAIL sim_r%0d_g%0d_addr: got %0h wen=%0h expected %0h/0", r, g, bus.m_req_addr, bus.m_req_wen, (exp_d ? 32'h200 : 32'h40)); end
        bus.m_req_ready = 1'b1;
        #1;
        checks++; if (bus.d_req_ready !== exp_d || bus.i_req_ready !== ~exp_d) begin errors++; $display("FAIL sim_r%0d_g%0d_ready: got d=%0h i=%0h expected d=%0h", r, g, bus.d_req_ready, bus.i_req_ready, exp_d); end
        tick();  // -> RSP
        bus.m_req_ready = 1'b0;
        if (exp_d) bus.d_req_rd = 1'b0; else bus.i_req_valid = 1'b0;
        bus.m_rsp_valid = 1'b1; bus.m_rsp_data = exp_data;
        bus.i_rsp_ready = 1'b1; bus.d_rsp_ready = 1'b1;
        #1;
        checks++; if (bus.d_rsp_valid !== exp_d || bus.i_rsp_valid !== ~exp_d) begin errors++; $display("FAIL sim_r%0d_g%0d_rsp: got d=%0h i=%0h expected d=%0h", r, g, bus.d_rsp_valid, bus.i_rsp_valid, exp_d); end
        checks++; if ((exp_d ? bus.d_rsp_data : bus.i_rsp_data) !== exp_data) begin errors++; $display("FAIL sim_r%0d_g%0d_data: got %0h expected %0h", r, g, (exp_d ? bus.d_rsp_data : bus.i_rsp_data), exp_data); end
        tick();  // -> IDLE
        bus.m_rsp_valid = 1'b0; bus.i_rsp_ready = 1'b0; bus.d_rsp_ready = 1'b0;
      end
    end
    #1;
    checks++; if (cnt_grant_i !== 32'd3 || cnt_grant_d !== 32'd3) begin errors++; $display("FAIL sim_grants: got gi=%0d gd=%0d expected 3/3", cnt_grant_i, cnt_grant_d); end
  endtask

  task automatic test_rsp_backpressure();
    bus.d_req_rd = 1'b1; bus.d_req_addr = 32'h0000_0300;
    tick();  // -> REQ
    bus.m_req_ready = 1'b1;
    tick();  // -> RSP
    bus.d_req_rd = 1'b0; bus.m_req_ready = 1'b0;
    bus.m_rsp_valid = 1'b1; bus.m_rsp_data = 32'hCAFE_0001;
    for (int k = 0; k < 3; k++) begin
      bus.d_rsp_ready = (k == 2);
      #1;
      checks++; if (bus.m_rsp_ready !== (k == 2)) begin errors++; $display("FAIL bp_m_rsp_ready_c%0d: got %0h expected %0h", k, bus.m_rsp_ready, (k == 2)); end
      checks++; if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_data !== 32'hCAFE_0001 || bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_c%0d: got d_vld=%0h data=%0h i_vld=%0h expected 1/cafe0001/0", k, bus.d_rsp_valid, bus.d_rsp_data, bus.i_rsp_valid); end
      tick();
    end
    bus.m_rsp_valid = 1'b0; bus.d_rsp_ready = 1'b0;
    #1;
    checks++; if (bus.d_rsp_valid !== 1'b0 || bus.m_rsp_ready !== 1'b0 || cnt_grant_d !== 32'd4) begin errors++; $display("FAIL bp_done: got d_vld=%0h m_rdy=%0h gd=%0d expected 0/0/4", bus.d_rsp_valid, bus.m_rsp_ready, cnt_grant_d); end
  endtask

  task automatic test_proto_err();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_before: got %0h expected 0", proto_err); end
    bus.d_req_rd = 1'b1; bus.d_req_wr = 1'b1; bus.d_req_addr = 32'h0000_0400;
    bus.d_req_wdata = 32'h1122_3344; bus.d_req_wstrb = 4'h3;
    tick();  // -> REQ
    checks++; if (bus.m_req_wen !== 1'b1 || bus.m_req_wstrb !== 4'h3 || bus.m_req_wdata !== 32'h1122_3344) begin errors++; $display("FAIL perr_as_write: got wen=%0h strb=%0h wdata=%0h expected 1/3/11223344", bus.m_req_wen, bus.m_req_wstrb, bus.m_req_wdata); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %0h expected 1", proto_err); end
    bus.m_req_ready = 1'b1;
    tick();  // write handshake -> IDLE
    bus.d_req_rd = 1'b0; bus.d_req_wr = 1'b0; bus.m_req_ready = 1'b0;
    #1;
    checks++; if (bus.m_req_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin errors++; $display("FAIL perr_no_rsp: got m_vld=%0h d_vld=%0h expected 0", bus.m_req_valid, bus.d_rsp_valid); end
    tick(); tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %0h expected 1", proto_err); end
  endtask

  task automatic test_rst_in_rsp();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_0500;
    tick();  // -> REQ
    bus.m_req_ready = 1'b1;
    tick();  // -> RSP
    bus.i_req_valid = 1'b0; bus.m_req_ready = 1'b0;
    bus.m_rsp_valid = 1'b1; bus.m_rsp_data = 32'h5555_AAAA; bus.i_rsp_ready = 1'b0;
    #1;
    checks++; if (bus.i_rsp_valid !== 1'b1) begin errors++; $display("FAIL rstrsp_pending: got %0h expected 1", bus.i_rsp_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.i_rsp_valid !== 1'b0 || bus.m_rsp_ready !== 1'b0 || bus.m_req_valid !== 1'b0) begin errors++; $display("FAIL rstrsp_idle: got i_vld=%0h m_rdy=%0h m_vld=%0h expected 0", bus.i_rsp_valid, bus.m_rsp_ready, bus.m_req_valid); end
    checks++; if (cnt_grant_i !== 32'd0 || cnt_grant_d !== 32'd0 || cnt_stall !== 32'd0 || proto_err !== 1'b0) begin errors++; $display("FAIL rstrsp_counters: got gi=%0d gd=%0d st=%0d perr=%0h expected 0", cnt_grant_i, cnt_grant_d, cnt_stall, proto_err); end
    tick();
    checks++; if (bus.m_rsp_ready !== 1'b0 || bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstrsp_stray_rsp: got m_rdy=%0h i_vld=%0h expected 0", bus.m_rsp_ready, bus.i_rsp_valid); end
    bus.m_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_rsp_backpressure();
    test_proto_err();
    test_rst_in_rsp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
